bf16_int_frac_pipe: RTL and testbench
=====================================

Name: bf16_int_frac_pipe

Overview:
- Multi-lane, pipelined bf16 → (signed integer, fp16 fraction) splitter for the vector/activation datapath.
- Every lane computes x = I + F with I = trunc(x) toward zero, returned as a two's-complement integer, and F = x − I, returned as fp16 carrying x's sign.
- Valid/ready handshake on both sides; stalls without data loss.
- Adds sign handling, saturation, special-value flags and an overflow event counter.

Parameters:
- LANES, 4, number of independent bf16 lanes per beat
- INT_W, 32, integer output width (signed, 8..64)
- CNT_W, 16, width of the saturating overflow-event counter

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_bf16  in  LANES*16  lane i at [16i+15:16i]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_int  out  LANES*INT_W  signed integer part per lane
- out_frac  out  LANES*16  fp16 fractional part per lane
- out_ovf  out  LANES  integer saturated (|x| out of range, or ±Inf)
- out_nan  out  LANES  input was NaN
- cnt_clr  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_W  saturating count of overflow lane-events

Behaviour:
- Reset (async, nRST=0): both stage-valid flags = 0, all data registers = 0, ovf_count = 0. Resulting outputs: out_valid=0, out_int/out_frac/flags=0, in_ready=1. Reset mid-stream discards in-flight beats.
- Pipeline, 2 stages.
  - S1 registers: unpack, E = exp−127, sign, and the shifted integer/remainder.
  - S2 registers: saturation, fp16 pack, flags.
  - Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 beat/cycle.
- Handshake rules:
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
  - Outputs hold stable while out_valid && !out_ready. Order is preserved.
- flush: on the next edge clears both valids; an input presented that cycle is dropped. flush overrides accept.
- Per-lane arithmetic, in priority order:
  - exp==0xFF, mant≠0 (NaN): int=0, frac=0x7E00, nan=1, ovf=0.
  - exp==0xFF, mant==0 (±Inf): int=+max (0x7F..F) or −min (0x80..0), ovf=1, frac=±0.
  - exp==0 (zero or bf16 subnormal): int=0, frac=±0.
  - E ≥ INT_W−1: saturate as for Inf and set ovf=1. Exception: negative value exactly −2^(INT_W−1) (E=INT_W−1, mant=0) gives int=min with ovf=0.
  - E ≥ 7: int = ±({1,mant} << (E−7)), frac=±0.
  - 0 ≤ E < 7: magnitude int = {1,mant} >> (7−E); the remainder R is the low (7−E) bits; F = R·2^−(7−E).
  - E < 0: int=0, F=|x|.
  - Negative ints are two's-complement negated.
  - Fraction pack:
    - R==0 → sign-only zero (0x0000 / 0x8000).
    - Otherwise normalise with leading-one detect; Ef = unbiased exponent of F; fp16 = {sign, Ef+15, mantissa}. Exact, no rounding; at most 8 significant bits fit the 11-bit significand.
    - Ef < −14: flush to ±0 (see the optional feature).
- ovf_count:
  - On each output handshake, add popcount(out_ovf); saturates at all-ones.
  - cnt_clr wins over a simultaneous increment.

Optional Feature:
- Macro: BF16_FRAC_SUBNORM_EN.
- Defined: fractions with −24 ≤ Ef < −14 are emitted as fp16 subnormals (exp field 0, mantissa = significand >> (−14−Ef), truncated); Ef < −24 → ±0.
- Undefined: every Ef < −14 flushes to ±0.

Decomposition:
- Shared package bf16_pkg holds:
  - bf16_t / fp16_t packed structs {sign, exp, mant}
  - BF16_BIAS=127, FP16_BIAS=15, FP16_EMIN=−14, FP16_QNAN=16'h7E00
  - the lzc8 function
- One natural sub-module: bf16_int_frac_lane, the per-lane S1/S2 datapath with no handshake logic, instantiated LANES times by a generate loop. The top level owns valid/ready, flush and the counter.

Test Plan:
- 0x4060 (3.5) → int 0x00000003, frac 0x3800. 0xC030 (−2.75) → int 0xFFFFFFFE, frac 0xBA00. Both with latency exactly 2 cycles.
- 0x3E20 (0.15625) → int 0, frac 0x3100. 0x4100 (8.0) → int 8, frac 0x0000. 0xC100 (−8.0) → int 0xFFFFFFF8, frac 0x8000.
- INT_W=32: 0xCF00 (−2^31) → 0x80000000, ovf=0. 0x4F00 (2^31) → 0x7FFFFFFF, ovf=1. 0xFF80 (−Inf) → 0x80000000, ovf=1. The beat carrying 0x4F00 and 0xFF80 in one handshake makes ovf_count += 2. 0x7FC0 → int 0, frac 0x7E00, nan=1.
- 0x3580 (2^−20) → frac 0x0000 without the macro; 0x0010 with BF16_FRAC_SUBNORM_EN.
- Backpressure: out_ready=0 for 5 cycles while streaming 4 beats → in_ready drops after 2 accepts. After release, all 4 beats emerge in order, unchanged and stable while stalled.
- Apply flush with 2 beats in flight → out_valid=0 next cycle, no stale beat. Assert nRST mid-stream → outputs 0 immediately and ovf_count=0. cnt_clr coincident with an ovf beat → count=0.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bf16/fp16 field layouts, format constants and the leading-zero counter
// used by the bf16 integer/fraction splitter.
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] mant;
  } bf16_t;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  localparam int          BF16_BIAS = 127;
  localparam int          FP16_BIAS = 15;
  localparam int          FP16_EMIN = -14;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // Leading zeros of an 8-bit value; 8 when the value is zero.
  function automatic logic [3:0] lzc8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) n = 4'(7 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/bf16_int_frac_lane.sv
// One lane of the splitter: S1 decodes and shifts, S2 saturates and packs the fp16 fraction.
// Build option BF16_FRAC_SUBNORM_EN keeps tiny fractions as fp16 subnormals instead of zero.
module bf16_int_frac_lane
  import bf16_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en1,
  input  logic                    i_en2,
  input  logic [15:0]             i_bf16,
  output logic signed [INT_W-1:0] o_int,
  output logic [15:0]             o_frac,
  output logic                    o_ovf,
  output logic                    o_nan
);

  localparam logic signed [9:0] L_SEVEN = 10'sd7;
  localparam logic signed [9:0] L_EMAX  = 10'(INT_W - 1);
  localparam logic signed [9:0] L_BIAS  = 10'(BF16_BIAS);
  localparam logic signed [9:0] L_FBIAS = 10'(FP16_BIAS);
  localparam logic signed [9:0] L_EMIN  = 10'(FP16_EMIN);
`ifdef BF16_FRAC_SUBNORM_EN
  localparam logic signed [9:0] L_ESUB  = -10'sd24;
`endif
  localparam logic [INT_W-1:0]  L_MIN   = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0]  L_MAX   = ~L_MIN;

  bf16_t             w_x;
  logic signed [9:0] w_e;
  logic [7:0]        w_sig;
  logic              w_nan, w_sat, w_ovf;
  logic [INT_W-1:0]  w_mag;
  logic [7:0]        w_rem;

  assign w_x   = i_bf16;
  assign w_sig = {1'b1, w_x.mant};
  assign w_e   = signed'({2'b00, w_x.exp}) - L_BIAS;

  // Fraction is always r_rem * 2^(E-7), whichever side of the binary point E falls.
  always_comb begin
    w_nan = 1'b0;
    w_sat = 1'b0;
    w_ovf = 1'b0;
    w_mag = '0;
    w_rem = '0;
    if (w_x.exp == 8'hFF) begin
      if (w_x.mant != 7'd0) begin
        w_nan = 1'b1;
      end else begin
        w_sat = 1'b1;
        w_ovf = 1'b1;
      end
    end else if (w_x.exp != 8'h00) begin
      if (w_e >= L_EMAX) begin
        w_sat = 1'b1;
        w_ovf = !(w_x.sign && (w_e == L_EMAX) && (w_x.mant == 7'd0));
      end else if (w_e >= L_SEVEN) begin
        w_mag = INT_W'(w_sig) << (w_e - L_SEVEN);
      end else if (w_e >= 10'sd0) begin
        w_mag = INT_W'(w_sig >> (L_SEVEN - w_e));
        w_rem = w_sig & ((8'd1 << (L_SEVEN - w_e)) - 8'd1);
      end else begin
        w_rem = w_sig;
      end
    end
  end

  // ---- S1 register boundary ----
  logic              r_s1_sign, r_s1_nan, r_s1_sat, r_s1_ovf;
  logic [INT_W-1:0]  r_s1_mag;
  logic [7:0]        r_s1_rem;
  logic signed [9:0] r_s1_k;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_sign <= 1'b0;
      r_s1_nan  <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_ovf  <= 1'b0;
      r_s1_mag  <= '0;
      r_s1_rem  <= '0;
      r_s1_k    <= '0;
    end else if (i_en1) begin
      r_s1_sign <= w_x.sign;
      r_s1_nan  <= w_nan;
      r_s1_sat  <= w_sat;
      r_s1_ovf  <= w_ovf;
      r_s1_mag  <= w_mag;
      r_s1_rem  <= w_rem;
      r_s1_k    <= w_e - L_SEVEN;
    end
  end

  logic [3:0]        w_lz;
  logic signed [9:0] w_ef;
  logic [9:0]        w_man;
  fp16_t             w_frac;
  logic [INT_W-1:0]  w_int;

  assign w_lz  = lzc8(r_s1_rem);
  assign w_ef  = r_s1_k + (L_SEVEN - signed'({6'b000000, w_lz}));
  assign w_man = 10'({10'b0, r_s1_rem} << (w_lz + 4'd3));
`ifdef BF16_FRAC_SUBNORM_EN
  logic [10:0] w_sig11;
  assign w_sig11 = {1'b1, w_man};
`endif

  always_comb begin
    w_frac.sign = r_s1_sign;
    w_frac.exp  = 5'd0;
    w_frac.mant = 10'd0;
    if (r_s1_nan) begin
      w_frac = FP16_QNAN;
    end else if (r_s1_rem != 8'd0) begin
      if (w_ef >= L_EMIN) begin
        w_frac.exp  = 5'(w_ef + L_FBIAS);
        w_frac.mant = w_man;
      end
`ifdef BF16_FRAC_SUBNORM_EN
      else if (w_ef >= L_ESUB) begin
        w_frac.mant = 10'(w_sig11 >> (L_EMIN - w_ef));
      end
`endif
    end
  end

  assign w_int = r_s1_nan ? '0 :
                 r_s1_sat ? (r_s1_sign ? L_MIN : L_MAX) :
                 (r_s1_sign ? -r_s1_mag : r_s1_mag);

  // ---- S2 register boundary ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_int  <= '0;
      o_frac <= '0;
      o_ovf  <= 1'b0;
      o_nan  <= 1'b0;
    end else if (i_en2) begin
      o_int  <= w_int;
      o_frac <= w_frac;
      o_ovf  <= r_s1_ovf;
      o_nan  <= r_s1_nan;
    end
  end

endmodule

// File: rtl/bf16_int_frac_pipe.sv
// Multi-lane bf16 -> (signed integer, fp16 fraction) splitter with valid/ready, flush and an
// overflow-event counter. Build option BF16_FRAC_SUBNORM_EN enables fp16 subnormal fractions.
module bf16_int_frac_pipe
  import bf16_pkg::*;
#(
  parameter int LANES = 4,
  parameter int INT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*16-1:0]    in_bf16,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*INT_W-1:0] out_int,
  output logic [LANES*16-1:0]    out_frac,
  output logic [LANES-1:0]       out_ovf,
  output logic [LANES-1:0]       out_nan,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       ovf_count
);

  logic r_s1_valid, r_s2_valid;
  logic w_s1_adv, w_s2_adv, w_en1, w_en2, w_hs;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign w_hs      = r_s2_valid && out_ready;
  assign w_en1     = w_s1_adv && in_valid && !flush;
  assign w_en2     = w_s2_adv && r_s1_valid && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf16_int_frac_lane #(
      .INT_W(INT_W)
    ) u_lane (
      .i_clk  (CLK),
      .i_rst_n(nRST),
      .i_en1  (w_en1),
      .i_en2  (w_en2),
      .i_bf16 (in_bf16[16*g +: 16]),
      .o_int  (out_int[INT_W*g +: INT_W]),
      .o_frac (out_frac[16*g +: 16]),
      .o_ovf  (out_ovf[g]),
      .o_nan  (out_nan[g])
    );
  end

  logic [CNT_W:0]   w_pop, w_sum;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + (CNT_W+1)'(out_ovf[i]);
    end
  end

  assign w_sum = {1'b0, r_cnt} + w_pop;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hs) begin
      r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign ovf_count = r_cnt;

endmodule

// File: tb/tb_bf16_int_frac_pipe.sv
// Scoreboard bench for bf16_int_frac_pipe: a real-arithmetic reference model fills a queue on
// every accepted beat, and a monitor compares each delivered beat and the overflow counter.
module tb_bf16_int_frac_pipe;

  localparam int LANES = 4;
  localparam int IW    = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic                CLK, nRST, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [LANES*16-1:0] in_bf16;
  logic [LANES*IW-1:0] out_int;
  logic [LANES*16-1:0] out_frac;
  logic [LANES-1:0]    out_ovf, out_nan;
  logic [CW-1:0]       ovf_count;

  bf16_int_frac_pipe #(.LANES(LANES), .INT_W(IW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_bf16(in_bf16), .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
    .out_frac(out_frac), .out_ovf(out_ovf), .out_nan(out_nan), .cnt_clr(cnt_clr),
    .ovf_count(ovf_count)
  );

  typedef struct {
    logic [LANES*IW-1:0] i;
    logic [LANES*16-1:0] f;
    logic [LANES-1:0]    o;
    logic [LANES-1:0]    n;
    int                  acc;
    bit                  lat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0, n_fail = 0, cyc = 0, model_cnt = 0;
  bit   hold;
  logic [LANES*IW-1:0] h_i;
  logic [LANES*16-1:0] h_f;
  logic [LANES-1:0]    h_o, h_n;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
    else        for (int k = 0; k < -e; k++) r = r / 2.0;
    return r;
  endfunction

  // Value-level model: x = I + F, I truncated toward zero, F = x - I as fp16.
  function automatic void ref_lane(input logic [15:0] b, output logic [31:0] ri,
                                   output logic [15:0] rf, output logic ro, output logic rn);
    logic s;
    int   ex, mt, ip, e;
    real  x, f, m;
    s  = b[15];
    ex = int'(b[14:7]);
    mt = int'(b[6:0]);
    ri = '0; rf = {s, 15'b0}; ro = 1'b0; rn = 1'b0;
    if (ex == 255 && mt != 0) begin
      rn = 1'b1;
      rf = 16'h7E00;
    end else if (ex == 255) begin
      ro = 1'b1;
      ri = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (ex != 0) begin
      x = (1.0 + real'(mt) / 128.0) * pow2(ex - 127);
      if (s && x == pow2(31)) begin
        ri = 32'h8000_0000;
      end else if (x >= pow2(31)) begin
        ro = 1'b1;
        ri = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        ip = $rtoi(x);
        f  = x - real'(ip);
        ri = s ? 32'(-ip) : 32'(ip);
        if (f > 0.0) begin
          m = f; e = 0;
          while (m < 1.0) begin m = m * 2.0; e--; end
          if (e >= -14) rf = {s, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
`ifdef BF16_FRAC_SUBNORM_EN
          else if (e >= -24) rf = {s, 5'd0, 10'($rtoi(f * pow2(24)))};
`endif
        end
      end
    end
  endfunction

  function automatic exp_t mk_exp(input logic [LANES*16-1:0] d);
    exp_t e;
    logic [31:0] ri;
    logic [15:0] rf;
    logic ro, rn;
    for (int l = 0; l < LANES; l++) begin
      ref_lane(d[16*l +: 16], ri, rf, ro, rn);
      e.i[IW*l +: IW] = ri;
      e.f[16*l +: 16] = rf;
      e.o[l] = ro;
      e.n[l] = rn;
    end
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic [15:0] rnd_bf16();
    logic s; logic [7:0] ex; logic [6:0] mt; int k;
    k  = int'($urandom_range(0, 9));
    s  = 1'($urandom_range(0, 1));
    mt = 7'($urandom);
    case (k)
      0:       begin ex = 8'hFF; if ($urandom_range(0, 1) == 0) mt = 7'd0; end
      1:       ex = 8'h00;
      2:       ex = 8'($urandom_range(150, 170));
      3, 4, 5: ex = 8'($urandom_range(120, 134));
      6:       ex = 8'($urandom_range(100, 119));
      7:       ex = 8'($urandom);
      default: ex = 8'($urandom_range(127, 157));
    endcase
    return {s, ex, mt};
  endfunction

  function automatic logic [LANES*16-1:0] rnd_beat();
    logic [LANES*16-1:0] d;
    for (int l = 0; l < LANES; l++) d[16*l +: 16] = rnd_bf16();
    return d;
  endfunction

  // One cycle of stimulus; expected beat pushed on acceptance, scoreboard emptied on flush.
  task automatic step(input logic v, input logic [LANES*16-1:0] d, input logic ordy,
                      input logic fl, input logic clr, input bit lat, output bit acc);
    exp_t e;
    @(negedge CLK);
    cyc++;
    in_valid = v; in_bf16 = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    #1;
    acc = v && in_ready && !fl;
    if (acc) begin
      e = mk_exp(d);
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
    #2;
    if (fl) q.delete();
  endtask

  // Monitor
  initial begin
    hold = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      chk("ovf_count", 128'(ovf_count), 128'(model_cnt));
      if (hold && out_valid) begin
        chk("stall_int",  128'(out_int),  128'(h_i));
        chk("stall_frac", 128'(out_frac), 128'(h_f));
        chk("stall_flag", 128'({out_ovf, out_nan}), 128'({h_o, h_n}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got int %h frac %h, expected no beat", out_int, out_frac);
        end else begin
          m_e = q.pop_front();
          chk("int",  128'(out_int),  128'(m_e.i));
          chk("frac", 128'(out_frac), 128'(m_e.f));
          chk("ovf",  128'(out_ovf),  128'(m_e.o));
          chk("nan",  128'(out_nan),  128'(m_e.n));
          if (m_e.lat) chk("latency", 128'(cyc - m_e.acc), 128'd2);
          model_cnt = model_cnt + $countones(m_e.o);
          if (model_cnt > CMAX) model_cnt = CMAX;
        end
      end
      if (cnt_clr) model_cnt = 0;
      hold = out_valid && !out_ready;
      h_i = out_int; h_f = out_frac; h_o = out_ovf; h_n = out_nan;
    end
  end

  // Driver
  logic [LANES*16-1:0] bp[4];
  bit a;
  int idx, accs;

  initial begin
    nRST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; in_bf16 = '0;
    #1 nRST = 1'b0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_int",       128'(out_int),   128'd0);
    chk("rst_frac",      128'(out_frac),  128'd0);
    chk("rst_flags",     128'({out_ovf, out_nan}), 128'd0);
    chk("rst_count",     128'(ovf_count), 128'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Directed values, latency checked on each
    step(1, {16'h4100, 16'h3E20, 16'hC030, 16'h4060}, 1, 0, 0, 1, a);
    step(1, {16'h7FC0, 16'h3F80, 16'hCF00, 16'hC100}, 1, 0, 0, 1, a);
    step(1, {16'h0000, 16'h3580, 16'hFF80, 16'h4F00}, 1, 0, 0, 1, a);
    for (int c = 0; c < 4; c++) step(0, '0, 1, 0, 0, 0, a);

    // Counter clear coincident with an overflow handshake
    step(1, {16'h0000, 16'h7F80, 16'hFF80, 16'h4F00}, 1, 0, 0, 0, a);
    step(0, '0, 1, 0, 0, 0, a);
    step(0, '0, 1, 0, 1, 0, a);
    step(0, '0, 1, 0, 0, 0, a);
    chk("cnt_clr_wins", 128'(ovf_count), 128'd0);
    for (int c = 0; c < 2; c++) step(0, '0, 1, 0, 0, 0, a);

    // Backpressure: 5 stalled cycles while offering 4 beats
    bp[0] = {16'h4060, 16'hC030, 16'h3E20, 16'h4100};
    bp[1] = {16'hC100, 16'hCF00, 16'h4F00, 16'hFF80};
    bp[2] = {16'h7FC0, 16'h3580, 16'h4300, 16'hBF40};
    bp[3] = rnd_beat();
    idx = 0; accs = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, bp[idx < 4 ? idx : 3], 0, 0, 0, 0, a);
      if (a) begin accs++; idx++; end
    end
    chk("bp_accepts",  128'(accs), 128'd2);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step(1, bp[idx], 1, 0, 0, 0, a);
      if (a) idx++;
    end
    chk("bp_all_accepted", 128'(idx), 128'd4);
    for (int c = 0; c < 4; c++) step(0, '0, 1, 0, 0, 0, a);

    // Flush with two beats in flight; the beat offered with flush is dropped
    step(1, rnd_beat(), 1, 0, 0, 0, a);
    step(1, rnd_beat(), 1, 0, 0, 0, a);
    step(1, rnd_beat(), 0, 1, 0, 0, a);
    step(0, '0, 1, 0, 0, 0, a);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    for (int c = 0; c < 3; c++) step(0, '0, 1, 0, 0, 0, a);

    // Reset mid-stream after the counter has moved
    step(1, {16'h4060, 16'h4F00, 16'h7F80, 16'hFF80}, 1, 0, 0, 0, a);
    step(1, rnd_beat(), 1, 0, 0, 0, a);
    step(0, '0, 1, 0, 0, 0, a);
    @(negedge CLK);
    cyc++;
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1; nRST = 1'b0;
    #1;
    q.delete();
    model_cnt = 0;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_int",       128'(out_int),   128'd0);
    chk("mid_rst_frac",      128'(out_frac),  128'd0);
    chk("mid_rst_flags",     128'({out_ovf, out_nan}), 128'd0);
    chk("mid_rst_count",     128'(ovf_count), 128'd0);
    chk("mid_rst_in_ready",  128'(in_ready),  128'd1);
    #2 nRST = 1'b1;

    // Randomized traffic with backpressure, occasional flush and counter clear
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 7, rnd_beat(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, 0, a);
    end

    for (int c = 0; c < 50 && q.size() != 0; c++) step(0, '0, 1, 0, 0, 0, a);
    chk("drain", 128'(q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
